// File: rtl/bus_arb_pkg.sv
// Shared types for the bus host arbiter: lock-state enum and host-index sizing.
// Imported by the arbiter top and its order FIFO.
package bus_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } bus_arb_state_e;

    // A single host still needs one bit to carry its index through the order FIFO.
    function automatic int unsigned bus_arb_idx_w(input int unsigned nr_hosts);
        return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
    endfunction

    localparam int unsigned DefaultNrHosts = 3;

    typedef logic [bus_arb_idx_w(DefaultNrHosts)-1:0] host_idx_t;

endpackage

// File: rtl/bus_arb_order_fifo.sv
// In-order FIFO of issuing-host indices; head is valid whenever !empty.
// Latency: push visible at head the cycle after the write; pop takes effect on the clock edge.
// Backpressure: push ignored while full, pop ignored while empty; caller gates on full/empty.
module bus_arb_order_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps non-power-of-two depths correct as well.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CntW'(Depth));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Locked, outstanding-aware arbiter of NrHosts memory-bus hosts onto one device port; optional
// round-robin via BUS_HOST_ARBITER_ROUND_ROBIN_EN. Latency: request, grant and response routing are 0-cycle.
// Backpressure: no new issue while MaxOutstanding responses are pending; a stalled request stays locked.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts        = 3,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,

    input  logic [NrHosts-1:0]                     host_req_i,
    output logic [NrHosts-1:0]                     host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                     host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                     host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
    output logic [NrHosts-1:0]                     host_err_o,

    output logic                                   dev_req_o,
    output logic [AddressWidth-1:0]                dev_addr_o,
    output logic                                   dev_we_o,
    output logic [DataWidth/8-1:0]                 dev_be_o,
    output logic [DataWidth-1:0]                   dev_wdata_o,
    input  logic                                   dev_gnt_i,
    input  logic                                   dev_rvalid_i,
    input  logic [DataWidth-1:0]                   dev_rdata_i,
    input  logic                                   dev_err_i,

    output logic                                   protocol_err_o
);

    localparam int unsigned IdxW = bus_arb_idx_w(NrHosts);
    typedef logic [IdxW-1:0] idx_t;

    bus_arb_state_e state_q;
    bus_arb_state_e state_d;
    idx_t           lock_idx_q;
    idx_t           lock_idx_d;
    idx_t           pick_idx;
    idx_t           winner;
    idx_t           head_idx;
    logic           any_req;
    logic           issue_ok;
    logic           dev_req;
    logic           handshake;
    logic           resp_ok;
    logic           fifo_full;
    logic           fifo_empty;

    assign any_req  = |host_req_i;
    assign issue_ok = ~fifo_full;

`ifdef BUS_HOST_ARBITER_ROUND_ROBIN_EN
    idx_t rr_ptr;
    idx_t cand;

    // Walk backwards so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        pick_idx = '0;
        cand     = '0;
        for (int k = NrHosts - 1; k >= 0; k--) begin
            cand = idx_t'((int'(rr_ptr) + k) % NrHosts);
            if (host_req_i[cand]) begin
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (winner == idx_t'(NrHosts - 1)) ? '0 : winner + 1'b1;
        end
    end
`else
    always_comb begin
        pick_idx = '0;
        for (int k = NrHosts - 1; k >= 0; k--) begin
            if (host_req_i[k]) begin
                pick_idx = idx_t'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // A request that was offered but not granted must be re-offered unchanged, so the
    // winner is frozen; the FIFO cannot fill while locked, hence issue_ok is not consulted.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        winner     = pick_idx;
        dev_req    = issue_ok & any_req;
        case (state_q)
            IDLE: begin
                if (dev_req && !dev_gnt_i) begin
                    state_d    = LOCKED;
                    lock_idx_d = pick_idx;
                end
            end
            LOCKED: begin
                winner  = lock_idx_q;
                dev_req = 1'b1;
                if (dev_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign handshake = dev_req & dev_gnt_i;
    assign dev_req_o = dev_req;

    always_comb begin
        host_gnt_o  = '0;
        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        if (dev_req) begin
            dev_addr_o  = host_addr_i[winner];
            dev_we_o    = host_we_i[winner];
            dev_be_o    = host_be_i[winner];
            dev_wdata_o = host_wdata_i[winner];
        end
        if (handshake) begin
            host_gnt_o[winner] = 1'b1;
        end
    end

    bus_arb_order_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_order_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (handshake),
        .push_data (winner),
        .pop       (dev_rvalid_i),
        .head_data (head_idx),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign resp_ok = dev_rvalid_i & ~fifo_empty;

    always_comb begin
        host_rvalid_o = '0;
        if (resp_ok) begin
            host_rvalid_o[head_idx] = 1'b1;
        end
    end

    always_comb begin
        host_rdata_o = '0;
        host_err_o   = '0;
        for (int h = 0; h < NrHosts; h++) begin
            host_rdata_o[h] = dev_rdata_i;
            host_err_o[h]   = dev_err_i & host_rvalid_o[h];
        end
    end

    // Sticky until reset: a response with nothing outstanding means the device and
    // arbiter disagree about what is in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            protocol_err_o <= 1'b0;
        end else if (dev_rvalid_i && fifo_empty) begin
            protocol_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Randomized and directed bench for bus_host_arbiter, checked against a transaction-level model.
// Model: queue of outstanding host indices, one pending ungranted offer, sticky error flag.
module tb_bus_host_arbiter;

    localparam int N    = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         host_req;
    logic [N-1:0]         host_gnt;
    logic [N-1:0][AW-1:0] host_addr;
    logic [N-1:0]         host_we;
    logic [N-1:0][DW/8-1:0] host_be;
    logic [N-1:0][DW-1:0] host_wdata;
    logic [N-1:0]         host_rvalid;
    logic [N-1:0][DW-1:0] host_rdata;
    logic [N-1:0]         host_err;
    logic                 dev_req;
    logic [AW-1:0]        dev_addr;
    logic                 dev_we;
    logic [DW/8-1:0]      dev_be;
    logic [DW-1:0]        dev_wdata;
    logic                 dev_gnt;
    logic                 dev_rvalid;
    logic [DW-1:0]        dev_rdata;
    logic                 dev_err;
    logic                 protocol_err;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    int           q[$];
    int           pend;
    bit           perr;
    int           rr_ptr;
    int           exp_w;
    bit           exp_dreq;
    logic [N-1:0] exp_gnt;

    always #5 clk = ~clk;

    bus_host_arbiter #(
        .NrHosts        (N),
        .DataWidth      (DW),
        .AddressWidth   (AW),
        .MaxOutstanding (MAXO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .host_req_i     (host_req),
        .host_gnt_o     (host_gnt),
        .host_addr_i    (host_addr),
        .host_we_i      (host_we),
        .host_be_i      (host_be),
        .host_wdata_i   (host_wdata),
        .host_rvalid_o  (host_rvalid),
        .host_rdata_o   (host_rdata),
        .host_err_o     (host_err),
        .dev_req_o      (dev_req),
        .dev_addr_o     (dev_addr),
        .dev_we_o       (dev_we),
        .dev_be_o       (dev_be),
        .dev_wdata_o    (dev_wdata),
        .dev_gnt_i      (dev_gnt),
        .dev_rvalid_i   (dev_rvalid),
        .dev_rdata_i    (dev_rdata),
        .dev_err_i      (dev_err),
        .protocol_err_o (protocol_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int h;
`ifdef BUS_HOST_ARBITER_ROUND_ROBIN_EN
            h = (rr_ptr + k) % N;
`else
            h = k;
`endif
            if (r[h]) return h;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        pend   = -1;
        perr   = 1'b0;
        rr_ptr = 0;
    endtask

    task automatic check_model();
        logic [N-1:0] exp_rv;
        if (pend >= 0) begin
            exp_w = pend; exp_dreq = 1'b1;
        end else if (q.size() < MAXO && host_req != '0) begin
            exp_w = pick(host_req); exp_dreq = 1'b1;
        end else begin
            exp_w = 0; exp_dreq = 1'b0;
        end
        exp_gnt = '0;
        if (exp_dreq && dev_gnt) exp_gnt[exp_w] = 1'b1;
        check_eq("dev_req", dev_req, exp_dreq);
        check_eq("host_gnt", host_gnt, exp_gnt);
        if (exp_dreq) begin
            check_eq("dev_addr", dev_addr, host_addr[exp_w]);
            check_eq("dev_we", dev_we, host_we[exp_w]);
            check_eq("dev_be", dev_be, host_be[exp_w]);
            check_eq("dev_wdata", dev_wdata, host_wdata[exp_w]);
        end
        exp_rv = '0;
        if (dev_rvalid && q.size() > 0) exp_rv[q[0]] = 1'b1;
        check_eq("host_rvalid", host_rvalid, exp_rv);
        for (int h = 0; h < N; h++) begin
            if (exp_rv[h]) begin
                check_eq("host_rdata", host_rdata[h], dev_rdata);
                check_eq("host_err", host_err[h], dev_err);
            end
        end
        check_eq("protocol_err", protocol_err, perr);
    endtask

    task automatic model_update();
        if (dev_rvalid) begin
            if (q.size() > 0) void'(q.pop_front());
            else perr = 1'b1;
        end
        if (exp_dreq && dev_gnt) begin
            q.push_back(exp_w);
            pend   = -1;
            rr_ptr = (exp_w + 1) % N;
        end else if (exp_dreq) begin
            pend = exp_w;
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled at posedge+5.
    task automatic settle();
        #4;
    endtask

    task automatic finish_cycle();
        check_model();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        finish_cycle();
    endtask

    task automatic clear_inputs();
        host_req = '0; host_addr = '0; host_we = '0; host_be = '0; host_wdata = '0;
        dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_rdata = '0; dev_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_host(input int h, input logic [AW-1:0] a, input logic w,
                            input logic [DW/8-1:0] be, input logic [DW-1:0] d);
        host_addr[h] = a; host_we[h] = w; host_be[h] = be; host_wdata[h] = d;
    endtask

    task automatic rand_host(input int h);
        host_addr[h]  = $urandom;
        host_we[h]    = 1'($urandom_range(0, 1));
        host_be[h]    = 4'($urandom);
        host_wdata[h] = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && host_req != '0; i++) begin
            dev_gnt = 1'b1; dev_rvalid = (q.size() > 0); dev_rdata = $urandom;
            cycle();
            host_req = host_req & ~exp_gnt;
        end
        check_eq("req_flush_timeout", host_req, '0);
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            dev_gnt = 1'b0; dev_rvalid = 1'b1; dev_rdata = $urandom; dev_err = 1'($urandom_range(0, 1));
            cycle();
        end
        check_eq("drain_timeout", q.size(), 0);
        dev_rvalid = 1'b0; dev_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Reset state
        settle();
        check_eq("rst_dev_req", dev_req, 1'b0);
        check_eq("rst_host_gnt", host_gnt, '0);
        check_eq("rst_host_rvalid", host_rvalid, '0);
        check_eq("rst_protocol_err", protocol_err, 1'b0);
        finish_cycle();

        // Contention between hosts 0 and 2
        set_host(0, 32'hA0A0_0000, 1'b0, 4'hF, 32'h0);
        set_host(2, 32'hA2A2_0000, 1'b1, 4'h3, 32'hDEAD_BEEF);
        host_req = 3'b101; dev_gnt = 1'b1;
        settle(); check_eq("fp_gnt_first", host_gnt, 3'b001); finish_cycle();
        host_req = 3'b100;
        settle(); check_eq("fp_gnt_second", host_gnt, 3'b100); finish_cycle();
        host_req = 3'b000; dev_gnt = 1'b0; dev_rvalid = 1'b1; dev_rdata = 32'h1111_2222;
        settle(); check_eq("fp_rvalid_first", host_rvalid, 3'b001); finish_cycle();
        dev_rdata = 32'h3333_4444; dev_err = 1'b1;
        settle(); check_eq("fp_rvalid_second", host_rvalid, 3'b100); finish_cycle();
        dev_rvalid = 1'b0; dev_err = 1'b0;

        // Lock: host 2 stalled, host 0 arrives later
        host_req = 3'b100; dev_gnt = 1'b0;
        cycle();
        host_req = 3'b101;
        settle(); check_eq("lock_addr_c1", dev_addr, 32'hA2A2_0000); finish_cycle();
        settle(); check_eq("lock_addr_c2", dev_addr, 32'hA2A2_0000); finish_cycle();
        dev_gnt = 1'b1;
        settle(); check_eq("lock_gnt_held", host_gnt, 3'b100); finish_cycle();
        host_req = 3'b001;
        settle(); check_eq("lock_then_h0", host_gnt, 3'b001); finish_cycle();
        host_req = 3'b000;
        drain();

        // Full: two outstanding blocks a third issue
        set_host(1, 32'hA1A1_0000, 1'b1, 4'hC, 32'h0BAD_F00D);
        host_req = 3'b001; dev_gnt = 1'b1;
        cycle();
        host_req = 3'b010;
        cycle();
        host_req = 3'b100;
        settle(); check_eq("full_no_req", dev_req, 1'b0); finish_cycle();
        dev_rvalid = 1'b1;
        settle(); check_eq("full_pop_no_req", dev_req, 1'b0); finish_cycle();
        dev_rvalid = 1'b0;
        settle(); check_eq("full_reissue", host_gnt, 3'b100); finish_cycle();
        host_req = 3'b000;
        drain();

`ifdef BUS_HOST_ARBITER_ROUND_ROBIN_EN
        do_reset();
        begin
            logic [N-1:0] rr_exp [6];
            rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
            host_req = 3'b111; dev_gnt = 1'b1;
            for (int i = 0; i < 6; i++) begin
                dev_rvalid = (i > 0);
                settle(); check_eq("rr_seq", host_gnt, rr_exp[i]); finish_cycle();
            end
            host_req = 3'b000;
            drain();
        end
`endif

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            dev_gnt    = ($urandom_range(0, 3) != 0);
            dev_rvalid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            dev_rdata  = $urandom;
            dev_err    = 1'($urandom_range(0, 1));
            cycle();
            for (int h = 0; h < N; h++) begin
                if (!(host_req[h] && !exp_gnt[h])) begin
                    host_req[h] = ($urandom_range(0, 2) == 0);
                    rand_host(h);
                end
            end
        end
        drain();

        // Spurious response with nothing outstanding
        dev_rvalid = 1'b1; dev_gnt = 1'b0;
        settle(); check_eq("spur_no_rvalid", host_rvalid, '0); finish_cycle();
        dev_rvalid = 1'b0;
        settle(); check_eq("spur_perr_rise", protocol_err, 1'b1); finish_cycle();
        cycle(); cycle();
        settle(); check_eq("spur_perr_sticky", protocol_err, 1'b1); finish_cycle();

        // Reset with two transactions in flight
        do_reset();
        settle(); check_eq("rst_perr_cleared", protocol_err, 1'b0); finish_cycle();
        set_host(1, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
        set_host(0, 32'h0000_2000, 1'b1, 4'hF, 32'h1234_5678);
        host_req = 3'b010; dev_gnt = 1'b1;
        cycle();
        host_req = 3'b001;
        cycle();
        do_reset();
        settle();
        check_eq("mid_rst_dev_req", dev_req, 1'b0);
        check_eq("mid_rst_host_gnt", host_gnt, '0);
        check_eq("mid_rst_dev_addr", dev_addr, '0);
        check_eq("mid_rst_perr", protocol_err, 1'b0);
        finish_cycle();
        dev_rvalid = 1'b1;
        settle(); check_eq("mid_rst_stale_rvalid", host_rvalid, '0); finish_cycle();
        dev_rvalid = 1'b0;
        settle(); check_eq("mid_rst_stale_perr", protocol_err, 1'b1); finish_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
